// File: rtl/hex_ctrl_pkg.sv
// Shared constants and mode encoding for the HEX message scroller sequencer.
// Timing defaults assume a 50 MHz board clock.
package hex_ctrl_pkg;

  localparam int RATE_W = 6;

  localparam int CLK_HZ_DEF        = 50_000_000;
  localparam int ACC_W_DEF         = 26;
  localparam int RATE_MIN_DEF      = 1;
  localparam int RATE_MAX_DEF      = 50;
  localparam int RATE_INIT_DEF     = 3;
  localparam int DEB_CYCLES_DEF    = 500_000;
  localparam int REPEAT_CYCLES_DEF = 12_500_000;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_SCROLL = 2'b01,
    MODE_PAUSE  = 2'b10
  } mode_e;

endpackage

// File: rtl/key_debounce.sv
// One KEY input: 2-FF synchroniser, level debouncer, one-cycle press event
// and optional auto-repeat while the key stays held.
module key_debounce
  import hex_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter bit REPEAT_EN     = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          raw;
  logic          level;
  logic          level_next;
  logic          rise;
  logic          deb_done;
  logic          rep_fire;
  logic [DW-1:0] deb_cnt;

  // Debounced level is "pressed" = 1; raw is the synchronised key in the same sense.
  assign raw      = ~sync_p1;
  assign deb_done = (deb_cnt == DW'(DEB_CYCLES - 1));

  always_comb begin
    level_next = level;
    rise       = 1'b0;
    if ((raw != level) && deb_done) begin
      level_next = raw;
      rise       = raw;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      level   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_p0 <= key_n;
      sync_p1 <= sync_p0;
      level   <= level_next;
      if ((raw == level) || deb_done) begin
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  generate
    if (REPEAT_EN) begin : g_rep
      logic [RW-1:0] rep_cnt;
      logic          rep_done;

      assign rep_done = (rep_cnt == RW'(REPEAT_CYCLES - 1));
      assign rep_fire = level_next && !rise && rep_done;

      // Period counts from the press event; any release restarts it.
      always_ff @(posedge clk) begin
        if (reset || rise || !level_next || rep_done) begin
          rep_cnt <= '0;
        end else begin
          rep_cnt <= rep_cnt + RW'(1);
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      press <= 1'b0;
    end else begin
      press <= rise | rep_fire;
    end
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scroll sequencer: key handling, saturating rate register, drift-free step
// accumulator and the STATIC/SCROLL/PAUSE mode FSM driving the HEX rotator.
module hex_scroll_ctrl
  import hex_ctrl_pkg::*;
#(
  parameter int CLK_HZ        = CLK_HZ_DEF,
  parameter int ACC_W         = ACC_W_DEF,
  parameter int RATE_MIN      = RATE_MIN_DEF,
  parameter int RATE_MAX      = RATE_MAX_DEF,
  parameter int RATE_INIT     = RATE_INIT_DEF,
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              key_rrst_n,
  input  logic              key_up_n,
  input  logic              key_dn_n,
  input  logic              key_pause_n,
  input  logic              sw_static,
  output logic              step,
  output logic              load,
  output logic [RATE_W-1:0] rate,
  output logic [1:0]        mode,
  output logic              blink
);

  logic ev_rrst;
  logic ev_up;
  logic ev_dn;
  logic ev_pause;

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0)
  ) u_key_rrst (
    .clk(CLOCK_50), .reset(reset), .key_n(key_rrst_n), .press(ev_rrst)
  );

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)
  ) u_key_up (
    .clk(CLOCK_50), .reset(reset), .key_n(key_up_n), .press(ev_up)
  );

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b1)
  ) u_key_dn (
    .clk(CLOCK_50), .reset(reset), .key_n(key_dn_n), .press(ev_dn)
  );

  key_debounce #(
    .DEB_CYCLES(DEB_CYCLES), .REPEAT_CYCLES(REPEAT_CYCLES), .REPEAT_EN(1'b0)
  ) u_key_pause (
    .clk(CLOCK_50), .reset(reset), .key_n(key_pause_n), .press(ev_pause)
  );

  // Up wins over down when both arrive together; neither end wraps.
  function automatic logic [RATE_W-1:0] sat_rate(input logic [RATE_W-1:0] r,
                                                 input logic up,
                                                 input logic dn);
    logic [RATE_W-1:0] res;
    res = r;
    if (up) begin
      if (r < RATE_W'(RATE_MAX)) res = r + RATE_W'(1);
    end else if (dn) begin
      if (r > RATE_W'(RATE_MIN)) res = r - RATE_W'(1);
    end
    return res;
  endfunction

  logic [RATE_W-1:0] rate_next;

  always_comb begin
    if (ev_rrst) begin
      rate_next = RATE_W'(RATE_INIT);
    end else begin
      rate_next = sat_rate(rate, ev_up, ev_dn);
    end
  end

  mode_e state;
  mode_e state_next;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= MODE_STATIC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (sw_static) begin
      state_next = MODE_STATIC;
    end else begin
      case (state)
        MODE_STATIC: state_next = MODE_SCROLL;
        MODE_SCROLL: if (ev_pause) state_next = MODE_PAUSE;
        MODE_PAUSE:  if (ev_pause) state_next = MODE_SCROLL;
        default:     state_next = MODE_STATIC;
      endcase
    end
  end

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic             step_next;
  logic             load_next;
  logic             blink_next;

  assign acc_sum = acc + ACC_W'(rate);

  // Outputs are decided from the mode being entered, so a registered step
  // only ever appears alongside mode=SCROLL and never alongside load.
  always_comb begin
    acc_next   = acc;
    step_next  = 1'b0;
    load_next  = 1'b0;
    blink_next = blink;
    case (state_next)
      MODE_STATIC: begin
        acc_next   = '0;
        blink_next = 1'b0;
        load_next  = (state != MODE_STATIC);
      end
      MODE_SCROLL: begin
        if (acc_sum >= ACC_W'(CLK_HZ)) begin
          acc_next   = acc_sum - ACC_W'(CLK_HZ);
          step_next  = 1'b1;
          blink_next = ~blink;
        end else begin
          acc_next = acc_sum;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rate  <= RATE_W'(RATE_INIT);
      acc   <= '0;
      step  <= 1'b0;
      load  <= 1'b1;
      blink <= 1'b0;
    end else begin
      rate  <= rate_next;
      acc   <= acc_next;
      step  <= step_next;
      load  <= load_next;
      blink <= blink_next;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Randomised bench for hex_scroll_ctrl against a behavioural model built from
// key windows, press timestamps and modular accumulator arithmetic.
module tb_hex_scroll_ctrl;

  localparam int HZ  = 100;
  localparam int DEB = 4;
  localparam int REP = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_rrst_n = 1'b1;
  logic       key_up_n = 1'b1;
  logic       key_dn_n = 1'b1;
  logic       key_pause_n = 1'b1;
  logic       sw_static = 1'b0;
  logic       step;
  logic       load;
  logic [5:0] rate;
  logic [1:0] mode;
  logic       blink;

  always #5 clk = ~clk;

  hex_scroll_ctrl #(
    .CLK_HZ(HZ), .DEB_CYCLES(DEB), .REPEAT_CYCLES(REP)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .key_rrst_n(key_rrst_n), .key_up_n(key_up_n),
    .key_dn_n(key_dn_n), .key_pause_n(key_pause_n), .sw_static(sw_static),
    .step(step), .load(load), .rate(rate), .mode(mode), .blink(blink)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model; key index 0 rrst, 1 up, 2 dn, 3 pause.
  bit [1:0]     m_pipe [4];
  bit [DEB-1:0] m_win  [4];
  bit           m_lvl  [4];
  bit           m_ev   [4];
  int           m_tp   [4];
  int           m_cyc = 0;
  int           m_rate, m_acc, m_mode;
  bit           m_step, m_load, m_blink;

  task automatic model_edge(input bit rst, input bit [3:0] keys_n, input bit sw);
    bit ev_prev [4];
    int nrate;
    int nmode;
    int s;
    m_cyc++;
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        m_pipe[k] = 2'b11;
        m_win[k]  = '0;
        m_lvl[k]  = 1'b0;
        m_ev[k]   = 1'b0;
        m_tp[k]   = 0;
      end
      m_rate = 3; m_acc = 0; m_mode = 0;
      m_step = 1'b0; m_load = 1'b1; m_blink = 1'b0;
      return;
    end
    ev_prev = m_ev;
    for (int k = 0; k < 4; k++) begin
      bit pressed;
      pressed   = !m_pipe[k][1];
      m_pipe[k] = {m_pipe[k][0], keys_n[k]};
      m_win[k]  = {m_win[k][DEB-2:0], pressed};
      m_ev[k]   = 1'b0;
      if (!m_lvl[k] && (&m_win[k])) begin
        m_lvl[k] = 1'b1;
        m_ev[k]  = 1'b1;
        m_tp[k]  = m_cyc;
      end else if (m_lvl[k] && (m_win[k] == '0)) begin
        m_lvl[k] = 1'b0;
      end else if (m_lvl[k] && (k == 1 || k == 2) && ((m_cyc - m_tp[k]) % REP == 0)) begin
        m_ev[k] = 1'b1;
      end
    end
    nrate = m_rate;
    if (ev_prev[0]) nrate = 3;
    else if (ev_prev[1]) nrate = (m_rate < 50) ? m_rate + 1 : m_rate;
    else if (ev_prev[2]) nrate = (m_rate > 1) ? m_rate - 1 : m_rate;
    if (sw) nmode = 0;
    else if (m_mode == 0) nmode = 1;
    else if (ev_prev[3]) nmode = (m_mode == 1) ? 2 : 1;
    else nmode = m_mode;
    m_load = (nmode == 0) && (m_mode != 0);
    m_step = 1'b0;
    if (nmode == 0) begin
      m_acc   = 0;
      m_blink = 1'b0;
    end else if (nmode == 1) begin
      s = m_acc + m_rate;
      if (s >= HZ) begin
        m_acc   = s - HZ;
        m_step  = 1'b1;
        m_blink = !m_blink;
      end else begin
        m_acc = s;
      end
    end
    m_rate = nrate;
    m_mode = nmode;
  endtask

  int step_cnt = 0;
  int load_cnt = 0;
  int rate_max = 0;

  task automatic tick();
    @(posedge clk);
    model_edge(reset, {key_pause_n, key_dn_n, key_up_n, key_rrst_n}, sw_static);
    #1;
    check("step", step, m_step);
    check("load", load, m_load);
    check("rate", rate, m_rate);
    check("mode", mode, m_mode);
    check("blink", blink, m_blink);
    if (step === 1'b1) step_cnt++;
    if (load === 1'b1) load_cnt++;
    if (int'(rate) > rate_max) rate_max = int'(rate);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_rrst_n = v;
      1: key_up_n = v;
      2: key_dn_n = v;
      default: key_pause_n = v;
    endcase
  endtask

  task automatic press(input int k, input int n_low, input int n_high);
    set_key(k, 1'b0);
    run(n_low);
    set_key(k, 1'b1);
    run(n_high);
  endtask

  int saved;

  initial begin
    // reset and free-running scroll at rate 3
    run(4);
    reset = 1'b0;
    run(1);
    check("mode_after_reset", mode, 1);
    step_cnt = 0;
    run(99);
    check("steps_first_100", step_cnt, 3);
    step_cnt = 0;
    run(100);
    check("steps_second_100", step_cnt, 3);

    // held up key: repeat until saturation
    rate_max = 0;
    key_up_n = 1'b0;
    run(1000);
    key_up_n = 1'b1;
    run(10);
    check("rate_sat_max", rate, 50);
    check("rate_max_seen", rate_max, 50);

    // repeated down pulses
    for (int i = 0; i < 60; i++) press(2, $urandom_range(6, 12), $urandom_range(6, 12));
    check("rate_sat_min", rate, 1);

    // rate reset beats up
    key_rrst_n = 1'b0;
    key_up_n   = 1'b0;
    run(10);
    key_rrst_n = 1'b1;
    key_up_n   = 1'b1;
    run(10);
    check("rrst_over_up", rate, 3);

    // pause mid-period then resume
    run($urandom_range(10, 40));
    press(3, 8, 4);
    check("mode_paused", mode, 2);
    step_cnt = 0;
    run(150);
    check("no_step_paused", step_cnt, 0);
    press(3, 8, 60);
    check("mode_resumed", mode, 1);

    // static from scroll, with glitches on every key
    saved = int'(rate);
    load_cnt = 0;
    step_cnt = 0;
    sw_static = 1'b1;
    run(3);
    for (int k = 0; k < 4; k++) press(k, 3, 8);
    check("glitch_rate", rate, saved);
    check("static_mode", mode, 0);
    check("static_load_once", load_cnt, 1);
    check("static_no_step", step_cnt, 0);
    check("static_blink", blink, 0);
    sw_static = 1'b0;
    run(30);

    // static from pause
    press(3, 8, 10);
    load_cnt = 0;
    sw_static = 1'b1;
    run(20);
    check("pause_to_static_load", load_cnt, 1);
    sw_static = 1'b0;
    run(5);

    // set rate 20 then reset mid-scroll
    for (int i = 0; i < 17; i++) press(1, 8, 8);
    check("rate_20", rate, 20);
    run($urandom_range(5, 40));
    reset = 1'b1;
    tick();
    check("rst_rate", rate, 3);
    check("rst_mode", mode, 0);
    check("rst_step", step, 0);
    check("rst_load", load, 1);
    reset = 1'b0;

    // random soak
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 11) == 0) begin
          case (k)
            0: key_rrst_n = ~key_rrst_n;
            1: key_up_n = ~key_up_n;
            2: key_dn_n = ~key_dn_n;
            default: key_pause_n = ~key_pause_n;
          endcase
        end
      end
      if ($urandom_range(0, 199) == 0) sw_static = ~sw_static;
      reset = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0;
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
